// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared front-end definitions: datapath width, the default reset PC,
// the instruction size used for sequential fetch, and the ALU / PC-mode
// encodings shared with the execute stage.
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

  // Instruction, address and PC width.
  localparam int DEF_WORD_BITS = 32;

  // First PC fetched after reset (must be word aligned).
  localparam logic [DEF_WORD_BITS-1:0] DEF_RESET_PC = 32'h0000_0000;

  // Bytes per instruction; sequential fetch advances the PC by this amount.
  localparam int INSTR_BYTES = 4;

  // Source of the next PC as seen by execute.
  typedef enum logic [1:0] {
    PC_MODE_SEQ,
    PC_MODE_BRANCH,
    PC_MODE_JAL,
    PC_MODE_JALR
  } pc_mode_e;

  // ALU operation encodings used by decode/execute.
  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_e;

endpackage

// File: rtl/fetch_unit_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small instruction buffer between the memory response path and decode.
// Ports:
//   clk, reset       - clock and synchronous active-high reset
//   clear            - synchronous flush (pointers and count to zero)
//   push, push_data  - write one entry at the tail
//   pop              - drop the head entry (caller guarantees non-empty)
//   head_data        - current head entry, driven from storage flops
//   count            - occupancy, 0..DEPTH
// Push and pop may happen in the same cycle; the caller guarantees that a
// push into a full FIFO only happens together with a pop.
// ---------------------------------------------------------------------------
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state for storage, pointers and occupancy. DEPTH is a power of two,
  // so the pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is zeroed on reset so the head reads as zero before any fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage feeding the decoder. Issues in-order word fetches,
// buffers returned words with their PCs, and restarts at a new PC on redirect.
// Ports:
//   clk, reset                          - clock, synchronous active-high reset
//   imem_req_valid/ready, imem_req_addr - request channel to instruction memory
//   imem_resp_valid, imem_resp_data     - in-order responses, never stalled
//   redirect_valid, redirect_pc         - flush and restart from redirect_pc
//   instr_valid/ready, instr, instr_pc  - instruction stream to decode
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   WORD_BITS  = DEF_WORD_BITS,
  parameter int                   FIFO_DEPTH = 2,
  parameter logic [WORD_BITS-1:0] RESET_PC   = DEF_RESET_PC
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [WORD_BITS-1:0] imem_req_addr,
  input  logic                 imem_resp_valid,
  input  logic [WORD_BITS-1:0] imem_resp_data,
  input  logic                 redirect_valid,
  input  logic [WORD_BITS-1:0] redirect_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [WORD_BITS-1:0] instr,
  output logic [WORD_BITS-1:0] instr_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [WORD_BITS-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_BITS-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0]       fifo_count;
  logic [2*WORD_BITS-1:0] fifo_head;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic [CNT_W:0]         credits_used;
  logic                   req_fire;
  logic                   resp_ok;
  logic [WORD_BITS-1:0]   redirect_aligned;

  assign redirect_aligned = redirect_pc & ~WORD_BITS'(3);

  // In-flight plus buffered entries never exceed FIFO_DEPTH, which is what
  // lets responses be accepted unconditionally.
  assign credits_used   = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req_valid = !reset && !redirect_valid
                          && (credits_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok = imem_resp_valid && (outstanding_q != '0);

  assign fifo_push = resp_ok && (drop_cnt_q == '0) && !redirect_valid;
  assign fifo_pop  = instr_valid && instr_ready && !redirect_valid;

  // PC, credit and drop bookkeeping. On redirect every request still in
  // flight after this cycle belongs to the old stream and must be dropped.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;

    case ({req_fire, resp_ok})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      drop_cnt_d = outstanding_d;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + WORD_BITS'(INSTR_BYTES);
      end
      if (resp_ok && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
      if (fifo_push) begin
        resp_pc_d = resp_pc_q + WORD_BITS'(INSTR_BYTES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * WORD_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (fifo_push),
    .push_data ({resp_pc_q, imem_resp_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  assign instr_valid = (fifo_count != '0);
  assign instr_pc    = fifo_head[2*WORD_BITS-1:WORD_BITS];
  assign instr       = fifo_head[WORD_BITS-1:0];

  a_no_orphan_resp : assert property (
    @(posedge clk) disable iff (reset) imem_resp_valid |-> (outstanding_q != '0)
  );

endmodule
